// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the 8 x 16-bit register file and
// its sequential reader. The reader's optional checksum word is enabled with
// REGFILE_READER_CHECKSUM_EN. That macro adds the SUM state to the enum.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    // Word counter must hold NUM_REGS itself, so it needs one extra bit.
    localparam int CNT_W    = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
`ifdef REGFILE_READER_CHECKSUM_EN
        SUM   = 3'd3,
`endif
        DONE  = 3'd4
    } reader_state_t;

    // A requested count of zero means a full sweep of the register file.
    function automatic logic [CNT_W-1:0] count_to_words(input logic [ADDR_W-1:0] c);
        return (c == '0) ? CNT_W'(NUM_REGS) : {1'b0, c};
    endfunction

endpackage

// File: rtl/regfile_reader_if.sv
// Bus between the register-file reader and its environment: start request,
// status, register-file read port and the valid/ready output stream.
// The master side is the reader. The slave side is the requester, the
// register file and the downstream consumer.
interface regfile_reader_if;
    import regfile_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  start, start_addr, count, r_data, out_ready,
        output busy, done, r_addr, out_data, out_valid, out_last
    );

    modport slave (
        output start, start_addr, count, r_data, out_ready,
        input  busy, done, r_addr, out_data, out_valid, out_last
    );

endinterface

// File: rtl/regfile.sv
// 8 x 16-bit register file: one synchronous write port and one
// combinational read port.
module regfile
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Write port: contents are not reset, the owner loads them explicitly.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/regfile_reader.sv
// Sequential read-out engine for the register file. On start it walks
// r_addr over a contiguous, wrapping address range and streams each word
// over a valid/ready handshake. Each word takes one FETCH cycle, which
// samples r_data, and at least one SEND cycle, which holds the word until
// it is accepted.
// Optional feature: REGFILE_READER_CHECKSUM_EN appends a modulo-2^16 sum of
// the streamed words as a final word, emitted from the SUM state.
module regfile_reader
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    regfile_reader_if.master bus
);

    reader_state_t     state;
    reader_state_t     state_nxt;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_c;
    logic              done_c;
    logic              xfer;
    logic              last_word;

`ifdef REGFILE_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction
`endif

    assign xfer      = out_valid_q && bus.out_ready;
    assign last_word = (remaining == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = FETCH;
            FETCH: state_nxt = SEND;
            SEND: begin
                if (xfer) begin
                    if (last_word) begin
`ifdef REGFILE_READER_CHECKSUM_EN
                        state_nxt = SUM;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
`ifdef REGFILE_READER_CHECKSUM_EN
            SUM:   if (xfer) state_nxt = DONE;
`endif
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy_c = (state != IDLE);
        done_c = (state == DONE);
    end

    // Address/remaining counters and the registered output word
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining   <= '0;
            r_addr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef REGFILE_READER_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remaining <= count_to_words(bus.count);
                        r_addr_q  <= bus.start_addr;
`ifdef REGFILE_READER_CHECKSUM_EN
                        checksum  <= '0;
`endif
                    end
                end
                FETCH: begin
                    // r_data is sampled here only; later writes do not touch the held word.
                    out_data_q  <= bus.r_data;
                    out_valid_q <= 1'b1;
`ifdef REGFILE_READER_CHECKSUM_EN
                    out_last_q  <= 1'b0;
                    checksum    <= wrap_add(checksum, bus.r_data);
`else
                    out_last_q  <= last_word;
`endif
                end
                SEND: begin
                    if (xfer) begin
                        remaining   <= remaining - CNT_W'(1);
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (last_word) begin
`ifdef REGFILE_READER_CHECKSUM_EN
                            // Preload the checksum word so it is valid throughout SUM.
                            out_data_q  <= checksum;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b1;
`endif
                        end else begin
                            r_addr_q <= r_addr_q + ADDR_W'(1);
                        end
                    end
                end
`ifdef REGFILE_READER_CHECKSUM_EN
                SUM: begin
                    if (xfer) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.r_addr    = r_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule
